// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router: header field layout, the illegal
// destination code and the transmitter state encoding.
package router_pkg;

    localparam int ADDR_LSB = 0;
    localparam int ADDR_W   = 2;
    localparam int LEN_LSB  = 2;
    localparam int LEN_W    = 6;

    localparam logic [1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        TX_IDLE    = 3'd0,
        TX_HEADER  = 3'd1,
        TX_PAYLOAD = 3'd2,
        TX_PARITY  = 3'd3,
        TX_GAP     = 3'd4
    } tx_state_t;

    // Build the header byte {len, addr} from the field layout above.
    function automatic logic [7:0] make_header(input logic [5:0] len, input logic [1:0] addr);
        logic [7:0] hdr;
        hdr = 8'h00;
        hdr[LEN_LSB +: LEN_W]   = len;
        hdr[ADDR_LSB +: ADDR_W] = addr;
        return hdr;
    endfunction

endpackage

// File: rtl/router_parity_acc.sv
// 8-bit XOR parity accumulator. 'load' restarts the accumulation with din,
// 'acc_en' folds din in. rd_data is a look-ahead read: it already includes
// the byte being folded in on this edge, so a caller can register the final
// parity in the same cycle the last byte is consumed. 'rd_inv' inverts the
// read value for error injection.
module router_parity_acc (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic       acc_en,
    input  logic       rd_inv,
    input  logic [7:0] din,
    output logic [7:0] rd_data
);

    logic [7:0] acc_r;
    logic [7:0] rd_base_s;

    function automatic logic [7:0] fold_byte(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

    // Accumulator register: load has priority over accumulate.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_r <= 8'h00;
        end else if (load) begin
            acc_r <= din;
        end else if (acc_en) begin
            acc_r <= fold_byte(acc_r, din);
        end else begin
            acc_r <= acc_r;
        end
    end

    // Look-ahead read with optional inversion.
    always_comb begin
        rd_base_s = acc_r;
        if (acc_en) begin
            rd_base_s = fold_byte(acc_r, din);
        end else begin
            rd_base_s = acc_r;
        end
        if (rd_inv) begin
            rd_data = ~rd_base_s;
        end else begin
            rd_data = rd_base_s;
        end
    end

endmodule

// File: rtl/router_pkt_tx.sv
// Packet transmitter feeding the router input port: header, payload
// (seed + k), parity, then a fixed idle gap. Every output is a register;
// busy only steers next-state logic, so holding a byte is simply "no update".
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int GAP_CYCLES = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_addr,
    input  logic [5:0] req_len,
    input  logic [7:0] req_seed,
    input  logic       req_bad_parity,
    input  logic       busy,
    output logic       pkt_valid,
    output logic [7:0] data_out,
    output logic       tx_done,
    output logic       req_err,
    output logic [7:0] pkt_count
);

    localparam logic [3:0] GAP_LIMIT = 4'(GAP_CYCLES);

    tx_state_t  state_r, state_nxt_s;
    logic [5:0] idx_r, idx_nxt_s;
    logic [3:0] gap_r, gap_nxt_s;
    logic [5:0] len_r;
    logic [7:0] seed_r;
    logic       bad_r;

    logic [7:0] data_nxt_s;
    logic       valid_nxt_s;
    logic       ready_nxt_s;
    logic       tx_done_nxt_s;
    logic       req_err_nxt_s;
    logic [7:0] count_nxt_s;
    logic       latch_s;
    logic       acc_load_s;
    logic       acc_en_s;
    logic [7:0] acc_din_s;
    logic [7:0] acc_rd_s;

    router_parity_acc u_parity (
        .clock   (clock),
        .reset   (reset),
        .load    (acc_load_s),
        .acc_en  (acc_en_s),
        .rd_inv  (bad_r),
        .din     (acc_din_s),
        .rd_data (acc_rd_s)
    );

    // Header is loaded at the handshake; otherwise the byte on data_out is folded in.
    always_comb begin
        if (acc_load_s) begin
            acc_din_s = make_header(req_len, req_addr);
        end else begin
            acc_din_s = data_out;
        end
    end

    // Next-state and next-output logic; defaults hold every register.
    always_comb begin
        state_nxt_s   = state_r;
        idx_nxt_s     = idx_r;
        gap_nxt_s     = gap_r;
        data_nxt_s    = data_out;
        valid_nxt_s   = pkt_valid;
        ready_nxt_s   = req_ready;
        tx_done_nxt_s = 1'b0;
        req_err_nxt_s = 1'b0;
        count_nxt_s   = pkt_count;
        latch_s       = 1'b0;
        acc_load_s    = 1'b0;
        acc_en_s      = 1'b0;
        case (state_r)
            TX_IDLE: begin
                ready_nxt_s = 1'b1;
                valid_nxt_s = 1'b0;
                data_nxt_s  = 8'h00;
                if (req_valid && req_ready) begin
                    if ((req_addr == ADDR_INVALID) || (req_len == 6'd0)) begin
                        req_err_nxt_s = 1'b1;
                    end else begin
                        latch_s     = 1'b1;
                        acc_load_s  = 1'b1;
                        state_nxt_s = TX_HEADER;
                        ready_nxt_s = 1'b0;
                        valid_nxt_s = 1'b1;
                        data_nxt_s  = make_header(req_len, req_addr);
                    end
                end else begin
                    state_nxt_s = TX_IDLE;
                end
            end
            TX_HEADER: begin
                if (!busy) begin
                    state_nxt_s = TX_PAYLOAD;
                    idx_nxt_s   = 6'd0;
                    data_nxt_s  = seed_r;
                end else begin
                    state_nxt_s = TX_HEADER;
                end
            end
            TX_PAYLOAD: begin
                if (!busy) begin
                    acc_en_s = 1'b1;
                    if (idx_r == (len_r - 6'd1)) begin
                        state_nxt_s = TX_PARITY;
                        valid_nxt_s = 1'b0;
                        data_nxt_s  = acc_rd_s;
                    end else begin
                        idx_nxt_s  = idx_r + 6'd1;
                        data_nxt_s = seed_r + {2'b00, idx_r + 6'd1};
                    end
                end else begin
                    state_nxt_s = TX_PAYLOAD;
                end
            end
            TX_PARITY: begin
                if (!busy) begin
                    state_nxt_s   = TX_GAP;
                    data_nxt_s    = 8'h00;
                    tx_done_nxt_s = 1'b1;
                    count_nxt_s   = pkt_count + 8'd1;
                    gap_nxt_s     = 4'd1;
                end else begin
                    state_nxt_s = TX_PARITY;
                end
            end
            TX_GAP: begin
                valid_nxt_s = 1'b0;
                data_nxt_s  = 8'h00;
                if (gap_r >= GAP_LIMIT) begin
                    state_nxt_s = TX_IDLE;
                    ready_nxt_s = 1'b1;
                end else begin
                    gap_nxt_s = gap_r + 4'd1;
                end
            end
            default: begin
                state_nxt_s = TX_IDLE;
                ready_nxt_s = 1'b0;
                valid_nxt_s = 1'b0;
                data_nxt_s  = 8'h00;
            end
        endcase
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= TX_IDLE;
            idx_r     <= 6'd0;
            gap_r     <= 4'd0;
            data_out  <= 8'h00;
            pkt_valid <= 1'b0;
            req_ready <= 1'b0;
            tx_done   <= 1'b0;
            req_err   <= 1'b0;
            pkt_count <= 8'd0;
        end else begin
            state_r   <= state_nxt_s;
            idx_r     <= idx_nxt_s;
            gap_r     <= gap_nxt_s;
            data_out  <= data_nxt_s;
            pkt_valid <= valid_nxt_s;
            req_ready <= ready_nxt_s;
            tx_done   <= tx_done_nxt_s;
            req_err   <= req_err_nxt_s;
            pkt_count <= count_nxt_s;
        end
    end

    // Request fields captured at a legal handshake and held for the packet.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            len_r  <= 6'd0;
            seed_r <= 8'h00;
            bad_r  <= 1'b0;
        end else if (latch_s) begin
            len_r  <= req_len;
            seed_r <= req_seed;
            bad_r  <= req_bad_parity;
        end else begin
            len_r  <= len_r;
            seed_r <= seed_r;
            bad_r  <= bad_r;
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: table-driven packets checked through
// an expected-byte queue, plus sequences for illegal requests, mid-packet
// reset and pkt_count wrap.
module tb_router_pkt_tx;

    localparam int GAP = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_addr;
    logic [5:0] req_len;
    logic [7:0] req_seed;
    logic       req_bad_parity;
    logic       busy;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       tx_done;
    logic       req_err;
    logic [7:0] pkt_count;

    always #5 clock = ~clock;

    router_pkt_tx #(.GAP_CYCLES(GAP)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_len        (req_len),
        .req_seed       (req_seed),
        .req_bad_parity (req_bad_parity),
        .busy           (busy),
        .pkt_valid      (pkt_valid),
        .data_out       (data_out),
        .tx_done        (tx_done),
        .req_err        (req_err),
        .pkt_count      (pkt_count)
    );

    typedef struct {
        logic [1:0] addr;
        logic [5:0] len;
        logic [7:0] seed;
        logic       bad;
        int         stall_idx;  // byte position (0 = header) held by busy, -1 none
        int         stall_len;
        logic [7:0] exp_hdr;
        logic       use_par;    // 1: exp_par is the expected parity constant
        logic [7:0] exp_par;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       valid;
    } exp_t;

    exp_t       exp_q[$];
    int         checks    = 0;
    int         failures  = 0;
    logic [7:0] exp_count = 8'd0;
    vec_t       vecs[6];
    vec_t       small_pkt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_parity(input logic [7:0] hdr, input logic [7:0] seed,
                                                input logic [5:0] len, input logic bad);
        logic [7:0] p;
        p = hdr;
        for (int k = 0; k < int'(len); k++) begin
            p = p ^ (seed + 8'(k));
        end
        return bad ? ~p : p;
    endfunction

    // Wait (bounded) for req_ready at a negedge.
    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("req_ready_wait", 32'(req_ready), 32'd1);
    endtask

    task automatic run_pkt(input vec_t v);
        exp_t       e;
        logic [7:0] par;
        int         held;
        int         b;
        int         vcount;
        int         n;
        wait_ready();
        exp_q.push_back('{v.exp_hdr, 1'b1});
        for (int k = 0; k < int'(v.len); k++) begin
            exp_q.push_back('{v.seed + 8'(k), 1'b1});
        end
        par = v.use_par ? v.exp_par : model_parity(v.exp_hdr, v.seed, v.len, v.bad);
        exp_q.push_back('{par, 1'b0});
        req_valid      = 1'b1;
        req_addr       = v.addr;
        req_len        = v.len;
        req_seed       = v.seed;
        req_bad_parity = v.bad;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        b      = 0;
        vcount = 0;
        while (exp_q.size() > 0) begin
            e    = exp_q.pop_front();
            held = (b == v.stall_idx) ? v.stall_len : 0;
            for (int h = 0; h <= held; h++) begin
                check("data_out", 32'(data_out), 32'(e.data));
                check("pkt_valid", 32'(pkt_valid), 32'(e.valid));
                check("tx_done_mid", 32'(tx_done), 32'd0);
                if (pkt_valid) vcount++;
                busy = (h < held);
                @(posedge clock);
                @(negedge clock);
            end
            busy = 1'b0;
            b++;
        end
        exp_count = exp_count + 8'd1;
        check("tx_done", 32'(tx_done), 32'd1);
        check("pkt_count", 32'(pkt_count), 32'(exp_count));
        check("valid_cycles", 32'(vcount),
              32'(int'(v.len) + 1 + ((v.stall_idx >= 0 && v.stall_idx <= int'(v.len)) ? v.stall_len : 0)));
        n = 0;
        while (!req_ready && n < 20) begin
            check("gap_valid", 32'(pkt_valid), 32'd0);
            check("gap_data", 32'(data_out), 32'd0);
            @(negedge clock);
            n++;
            if (n == 1) check("tx_done_pulse", 32'(tx_done), 32'd0);
        end
        check("gap_len", 32'(n), 32'(GAP));
    endtask

    task automatic illegal_req(input logic [1:0] a, input logic [5:0] l);
        wait_ready();
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
        req_seed  = 8'h55;
        busy      = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        busy      = 1'b0;
        check("req_err_pulse", 32'(req_err), 32'd1);
        check("illegal_valid", 32'(pkt_valid), 32'd0);
        check("illegal_ready", 32'(req_ready), 32'd1);
        @(negedge clock);
        check("req_err_clear", 32'(req_err), 32'd0);
        check("illegal_valid2", 32'(pkt_valid), 32'd0);
        check("illegal_data", 32'(data_out), 32'd0);
        check("illegal_count", 32'(pkt_count), 32'(exp_count));
    endtask

    initial begin
        vecs[0] = '{2'd1, 6'd3,  8'h10, 1'b0, -1, 0, 8'h0D, 1'b1, 8'h1E};
        vecs[1] = '{2'd1, 6'd3,  8'h10, 1'b0,  2, 2, 8'h0D, 1'b1, 8'h1E};
        vecs[2] = '{2'd2, 6'd63, 8'hF0, 1'b0, -1, 0, 8'hFE, 1'b0, 8'h00};
        vecs[3] = '{2'd2, 6'd63, 8'hF0, 1'b1, -1, 0, 8'hFE, 1'b0, 8'h00};
        vecs[4] = '{2'd0, 6'd1,  8'hFF, 1'b0,  2, 1, 8'h04, 1'b1, 8'hFB};
        vecs[5] = '{2'd2, 6'd5,  8'hA0, 1'b0,  0, 3, 8'h16, 1'b1, 8'hB2};
        small_pkt = '{2'd0, 6'd1, 8'h07, 1'b0, -1, 0, 8'h04, 1'b1, 8'h03};

        reset          = 1'b1;
        req_valid      = 1'b0;
        req_addr       = 2'd0;
        req_len        = 6'd0;
        req_seed       = 8'h00;
        req_bad_parity = 1'b0;
        busy           = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_valid", 32'(pkt_valid), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_tx_done", 32'(tx_done), 32'd0);
        check("rst_req_err", 32'(req_err), 32'd0);
        check("rst_count", 32'(pkt_count), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("ready_after_rst", 32'(req_ready), 32'd1);

        for (int i = 0; i < 6; i++) begin
            run_pkt(vecs[i]);
        end

        illegal_req(2'd3, 6'd5);
        illegal_req(2'd0, 6'd0);

        // Reset while payload byte 2 is on the wire.
        wait_ready();
        req_valid = 1'b1;
        req_addr  = 2'd1;
        req_len   = 6'd5;
        req_seed  = 8'h20;
        req_bad_parity = 1'b0;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            @(negedge clock);
        end
        check("pre_rst_byte", 32'(data_out), 32'h22);
        check("pre_rst_valid", 32'(pkt_valid), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("async_rst_valid", 32'(pkt_valid), 32'd0);
        check("async_rst_data", 32'(data_out), 32'd0);
        check("async_rst_ready", 32'(req_ready), 32'd0);
        check("async_rst_count", 32'(pkt_count), 32'd0);
        exp_count = 8'd0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_ready", 32'(req_ready), 32'd1);
        check("post_rst_tx_done", 32'(tx_done), 32'd0);
        check("post_rst_valid", 32'(pkt_valid), 32'd0);
        run_pkt(vecs[0]);

        // 255 more packets bring pkt_count from 1 through 255 back to 0.
        for (int i = 0; i < 255; i++) begin
            run_pkt(small_pkt);
        end
        check("count_wrap", 32'(pkt_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
